// File: rtl/mips_pkg.sv
// Shared pipeline encodings for the MIPS-R2000 datapath: control-bit indices and MEM-stage states.
// Includes a small alignment helper for word accesses.
package mips_pkg;

    localparam int M_BRANCH    = 2;
    localparam int M_READ      = 1;
    localparam int M_WRITE     = 0;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    function automatic logic word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; loads every cycle, bubble clears only the RegWrite bit.
// Latency: 1 cycle. No backpressure: writeback never stalls.
module mem_wb_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bubble,
    input  logic [4:0]  rd_in,
    input  logic        regwrite_in,
    input  logic        memtoreg_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] mem_in,
    output logic [4:0]  rd_q,
    output logic        regwrite_q,
    output logic        memtoreg_q,
    output logic [31:0] alu_q,
    output logic [31:0] mem_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            alu_q      <= '0;
            mem_q      <= '0;
        end else begin
            rd_q       <= rd_in;
            regwrite_q <= regwrite_in & ~bubble;
            memtoreg_q <= memtoreg_in;
            alu_q      <= alu_in;
            mem_q      <= mem_in;
        end
    end

endmodule

// File: rtl/memory_access.sv
// MEM stage: data-memory access over req/ready, MEM/WB register, writeback/forwarding outputs.
// Latency: 1 cycle to MEM/WB on zero-wait; stall held while dmem_ready is low, abort after TIMEOUT cycles.
module memory_access
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] res,
    input  logic [31:0] write_data_ex,
    input  logic [4:0]  write_register_ex,
    input  logic [2:0]  m_MEM,
    input  logic [1:0]  wb_MEM,
    input  logic        zero,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        branch_taken,
    output logic [4:0]  rd_WB,
    output logic        wb_WB,
    output logic [31:0] write_data_reg,
    output logic        align_err,
    output logic        bus_err
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    mem_state_t  state;
    logic [7:0]  cnt;
    logic [31:0] hold_addr;
    logic [31:0] hold_wdata;
    logic        hold_we;
    logic [4:0]  hold_rd;
    logic        hold_regwrite;
    logic        hold_memtoreg;

    logic        access;
    logic        aligned;
    logic        busy;
    logic        timed_out;
    logic        wb_bubble;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic        wb_memtoreg;
    logic [31:0] wb_alu;
    logic        memtoreg_q;
    logic [31:0] alu_q;
    logic [31:0] mem_q;

    assign branch_taken = m_MEM[M_BRANCH] & zero;

    always_comb begin
        access    = m_MEM[M_READ] | m_MEM[M_WRITE];
        aligned   = word_aligned(res);
        busy      = (state == BUSY);
        timed_out = busy && (cnt == TIMEOUT_C);

        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        dmem_addr   = '0;
        dmem_wdata  = '0;
        wb_bubble   = 1'b0;
        wb_rd       = write_register_ex;
        wb_regwrite = 1'b0;
        wb_memtoreg = 1'b0;
        wb_alu      = res;

        if (busy) begin
            // The timeout cycle drops req, so a late ready is simply not seen.
            dmem_req    = ~timed_out;
            dmem_we     = hold_we;
            dmem_addr   = hold_addr;
            dmem_wdata  = hold_wdata;
            wb_bubble   = ~(dmem_ready & ~timed_out);
            wb_rd       = hold_rd;
            wb_regwrite = hold_regwrite;
            wb_memtoreg = hold_memtoreg;
            wb_alu      = hold_addr;
        end else begin
            dmem_req    = access & aligned;
            dmem_we     = m_MEM[M_WRITE];
            dmem_addr   = {res[31:2], 2'b00};
            dmem_wdata  = write_data_ex;
            wb_bubble   = access & (~aligned | ~dmem_ready);
            wb_regwrite = wb_MEM[WB_REGWRITE] & ~m_MEM[M_WRITE];
            wb_memtoreg = wb_MEM[WB_MEMTOREG];
        end

        stall = dmem_req & ~dmem_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            hold_addr     <= '0;
            hold_wdata    <= '0;
            hold_we       <= 1'b0;
            hold_rd       <= '0;
            hold_regwrite <= 1'b0;
            hold_memtoreg <= 1'b0;
            align_err     <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            align_err <= 1'b0;
            bus_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (access && !aligned) begin
                        align_err <= 1'b1;
                    end else if (access && !dmem_ready) begin
                        state         <= BUSY;
                        cnt           <= 8'd1;
                        hold_addr     <= {res[31:2], 2'b00};
                        hold_wdata    <= write_data_ex;
                        hold_we       <= m_MEM[M_WRITE];
                        hold_rd       <= write_register_ex;
                        hold_regwrite <= wb_MEM[WB_REGWRITE] & ~m_MEM[M_WRITE];
                        hold_memtoreg <= wb_MEM[WB_MEMTOREG];
                    end
                end
                BUSY: begin
                    if (timed_out) begin
                        bus_err <= 1'b1;
                        state   <= IDLE;
                        cnt     <= '0;
                    end else if (dmem_ready) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .bubble      (wb_bubble),
        .rd_in       (wb_rd),
        .regwrite_in (wb_regwrite),
        .memtoreg_in (wb_memtoreg),
        .alu_in      (wb_alu),
        .mem_in      (dmem_rdata),
        .rd_q        (rd_WB),
        .regwrite_q  (wb_WB),
        .memtoreg_q  (memtoreg_q),
        .alu_q       (alu_q),
        .mem_q       (mem_q)
    );

    assign write_data_reg = memtoreg_q ? mem_q : alu_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: single-cycle vector table plus wait-state, timeout and reset sequences.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] res;
    logic [31:0] write_data_ex;
    logic [4:0]  write_register_ex;
    logic [2:0]  m_MEM;
    logic [1:0]  wb_MEM;
    logic        zero;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [4:0]  rd_WB;
    logic        wb_WB;
    logic [31:0] write_data_reg;
    logic        align_err;
    logic        bus_err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    memory_access #(.TIMEOUT(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .res               (res),
        .write_data_ex     (write_data_ex),
        .write_register_ex (write_register_ex),
        .m_MEM             (m_MEM),
        .wb_MEM            (wb_MEM),
        .zero              (zero),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_ready        (dmem_ready),
        .dmem_rdata        (dmem_rdata),
        .stall             (stall),
        .branch_taken      (branch_taken),
        .rd_WB             (rd_WB),
        .wb_WB             (wb_WB),
        .write_data_reg    (write_data_reg),
        .align_err         (align_err),
        .bus_err           (bus_err)
    );

    typedef struct {
        logic [31:0] res;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [2:0]  m;
        logic [1:0]  wb;
        logic        zero;
        logic        ready;
        logic [31:0] rdata;
        logic        exp_req;
        logic        exp_we;
        logic        exp_stall;
        logic        exp_branch;
        logic        exp_wb;
        logic        chk_data;
        logic [4:0]  exp_rd;
        logic [31:0] exp_wdr;
        logic        exp_align;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] r, input logic [31:0] wd, input logic [4:0] rd,
                         input logic [2:0] m, input logic [1:0] wb, input logic rdy, input logic [31:0] rdat);
        res               = r;
        write_data_ex     = wd;
        write_register_ex = rd;
        m_MEM             = m;
        wb_MEM            = wb;
        dmem_ready        = rdy;
        dmem_rdata        = rdat;
    endtask

    initial begin
        int req_cnt;
        int st_cnt;
        int be_cnt;
        int wb_cnt;

        rst_n = 1'b0;
        zero  = 1'b0;
        drive(32'h0, 32'h0, 5'd0, 3'b000, 2'b00, 1'b0, 32'h0);

        //                res           wdata         rd     m       wb     z     rdy   rdata         req   we    stl   br    wb    chkd  rd     wdr           al
        vecs[0] = '{32'h0000_0010, 32'h0,        5'd5,  3'b000, 2'b10, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5,  32'h0000_0010, 1'b0};
        vecs[1] = '{32'h0000_0100, 32'h0,        5'd7,  3'b010, 2'b11, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7,  32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{32'h0000_0102, 32'h0,        5'd9,  3'b010, 2'b11, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1};
        vecs[3] = '{32'h0000_0044, 32'h0,        5'd3,  3'b100, 2'b00, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3,  32'h0000_0044, 1'b0};
        vecs[4] = '{32'h0000_0300, 32'h0000_CAFE, 5'd2,  3'b001, 2'b10, 1'b0, 1'b1, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b0};
        vecs[5] = '{32'h0000_0055, 32'h0,        5'd1,  3'b000, 2'b10, 1'b0, 1'b1, 32'h0000_0099, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1,  32'h0000_0055, 1'b0};
        vecs[6] = '{32'h0000_0400, 32'h0000_0077, 5'd8,  3'b011, 2'b11, 1'b0, 1'b1, 32'h1111_2222, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b0};
        vecs[7] = '{32'h0000_0203, 32'h0000_0001, 5'd4,  3'b001, 2'b10, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1};
        vecs[8] = '{32'h0000_0000, 32'h0,        5'd31, 3'b000, 2'b10, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd31, 32'h0,         1'b0};

        #1;
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_rd_WB", 32'(rd_WB), 32'd0);
        chk("rst_wb_WB", 32'(wb_WB), 32'd0);
        chk("rst_wdr", write_data_reg, 32'h0);
        chk("rst_errs", {30'd0, align_err, bus_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].res, vecs[i].wdata, vecs[i].rd, vecs[i].m, vecs[i].wb, vecs[i].ready, vecs[i].rdata);
            zero = vecs[i].zero;
            #1;
            chk($sformatf("v%0d_req", i), 32'(dmem_req), 32'(vecs[i].exp_req));
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
            chk($sformatf("v%0d_branch", i), 32'(branch_taken), 32'(vecs[i].exp_branch));
            if (vecs[i].exp_req) begin
                chk($sformatf("v%0d_we", i), 32'(dmem_we), 32'(vecs[i].exp_we));
                chk($sformatf("v%0d_addr", i), dmem_addr, vecs[i].res);
                chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].wdata);
            end
            step();
            chk($sformatf("v%0d_wb_WB", i), 32'(wb_WB), 32'(vecs[i].exp_wb));
            chk($sformatf("v%0d_align", i), 32'(align_err), 32'(vecs[i].exp_align));
            chk($sformatf("v%0d_bus", i), 32'(bus_err), 32'd0);
            if (vecs[i].chk_data) begin
                chk($sformatf("v%0d_rd_WB", i), 32'(rd_WB), 32'(vecs[i].exp_rd));
                chk($sformatf("v%0d_wdr", i), write_data_reg, vecs[i].exp_wdr);
            end
        end
        zero = 1'b0;

        // Store with three wait states; EX inputs change under it and must be ignored.
        drive(32'h0000_0200, 32'h0000_1234, 5'd4, 3'b001, 2'b10, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            dmem_ready = (i == 3);
            #1;
            chk($sformatf("ws%0d_req", i), 32'(dmem_req), 32'd1);
            chk($sformatf("ws%0d_addr", i), dmem_addr, 32'h0000_0200);
            chk($sformatf("ws%0d_wdata", i), dmem_wdata, 32'h0000_1234);
            chk($sformatf("ws%0d_we", i), 32'(dmem_we), 32'd1);
            chk($sformatf("ws%0d_stall", i), 32'(stall), 32'(i != 3));
            step();
            chk($sformatf("ws%0d_wb_WB", i), 32'(wb_WB), 32'd0);
            if (i == 0) drive(32'hFFF0_0008, 32'h0, 5'd12, 3'b010, 2'b11, 1'b0, 32'h0);
        end
        drive(32'h0, 32'h0, 5'd0, 3'b000, 2'b00, 1'b0, 32'h0);
        #1;
        chk("ws_after_req", 32'(dmem_req), 32'd0);
        step();
        chk("ws_after_wb_WB", 32'(wb_WB), 32'd0);

        // Load that never sees ready: bounded by a 40-cycle loop.
        drive(32'h0000_0500, 32'h0, 5'd6, 3'b010, 2'b11, 1'b0, 32'h0);
        req_cnt = 0; st_cnt = 0; be_cnt = 0; wb_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (dmem_req) req_cnt++;
            if (stall) st_cnt++;
            step();
            if (bus_err) be_cnt++;
            if (wb_WB) wb_cnt++;
            if (i == 0) drive(32'h0, 32'h0, 5'd0, 3'b000, 2'b00, 1'b0, 32'h0);
        end
        chk("to_req_cycles", 32'(req_cnt), 32'd16);
        chk("to_stall_cycles", 32'(st_cnt), 32'd16);
        chk("to_bus_err_pulses", 32'(be_cnt), 32'd1);
        chk("to_wb_WB_ones", 32'(wb_cnt), 32'd0);
        chk("to_idle_req", 32'(dmem_req), 32'd0);

        // Reset during BUSY, then two zero-wait loads back to back.
        drive(32'h0000_0700, 32'h0, 5'd13, 3'b010, 2'b11, 1'b0, 32'h0);
        step(); step(); step();
        #1;
        chk("rb_busy_stall", 32'(stall), 32'd1);
        m_MEM = 3'b000;
        rst_n = 1'b0;
        #1;
        chk("rb_req", 32'(dmem_req), 32'd0);
        chk("rb_stall", 32'(stall), 32'd0);
        chk("rb_rd_WB", 32'(rd_WB), 32'd0);
        chk("rb_wb_WB", 32'(wb_WB), 32'd0);
        chk("rb_wdr", write_data_reg, 32'h0);
        chk("rb_errs", {30'd0, align_err, bus_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h0000_0600, 32'h0, 5'd10, 3'b010, 2'b11, 1'b1, 32'hA5A5_A5A5);
        #1;
        chk("bb0_req", 32'(dmem_req), 32'd1);
        chk("bb0_stall", 32'(stall), 32'd0);
        step();
        chk("bb0_wdr", write_data_reg, 32'hA5A5_A5A5);
        chk("bb0_rd_WB", 32'(rd_WB), 32'd10);
        chk("bb0_wb_WB", 32'(wb_WB), 32'd1);
        drive(32'h0000_0604, 32'h0, 5'd11, 3'b010, 2'b11, 1'b1, 32'h5A5A_0001);
        #1;
        chk("bb1_stall", 32'(stall), 32'd0);
        step();
        chk("bb1_wdr", write_data_reg, 32'h5A5A_0001);
        chk("bb1_rd_WB", 32'(rd_WB), 32'd11);
        chk("bb1_wb_WB", 32'(wb_WB), 32'd1);
        chk("bb_bus_err", 32'(bus_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
